instr_fetch: RTL and testbench



---
 rtl/core_pkg.sv | 36 +++
 rtl/fetch_fifo.sv | 50 +++++
 rtl/instr_fetch.sv | 150 +++++++++++++++
 tb/tb_instr_fetch.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV32 front-end types: opcodes, instruction field positions,
// the fetch queue entry and the fetch FSM state encoding.
package core_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; head is read combinationally.
// Push and pop may coincide at any occupancy, including full.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t rdata,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t mem [DEPTH];
  logic [AW:0]  wptr_q, rptr_q;
  logic         do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count   = wptr_q - rptr_q;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_q + (AW+1)'(do_push);
      rptr_q <= rptr_q + (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_fetch.sv
// RV32 fetch stage: PC, credit-limited imem requests, prefetch FIFO, redirect flush.
// Define FETCH_MISALIGN_EN to trap misaligned redirects and add fetch_misaligned.
module instr_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [6:0]  id_opcode,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_rs2,
  output logic [6:0]  id_funct7
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        fetch_misaligned
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, shadow_pc_q, target;
  logic         shadow_vld_q, hold_q;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW:0]  outstanding, inflight;
  logic         accept, keep, credit, mis;

  fetch_entry_t pcf_wdata, pcf_rdata, d_wdata, d_rdata;
  logic [CW-1:0] pcf_count, d_count;
  logic         pcf_full, pcf_empty, d_full, d_empty;

  assign target = redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_EN
  assign mis = |redirect_pc[1:0];
  assign fetch_misaligned = (state_q == TRAP);
`else
  assign mis = 1'b0;
`endif

  // Live requests in the PC queue plus stale ones still to be dropped.
  assign outstanding = {1'b0, pcf_count} + {1'b0, drop_q};
  assign inflight    = outstanding + {1'b0, d_count};
  assign credit      = (inflight < (CW+1)'(FIFO_DEPTH));

  assign imem_req_valid = hold_q | ((state_q == RUN) & credit);
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid & imem_req_ready;
  assign keep           = imem_rsp_valid & (drop_q == '0) & ~redirect_valid;

  assign pcf_wdata = '{instr: 32'h0, pc: pc_q};
  always_comb begin
    d_wdata       = pcf_rdata;
    d_wdata.instr = imem_rsp_data;
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_pc_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept & ~shadow_vld_q & ~pcf_full),
    .wdata (pcf_wdata),
    .pop   (keep & ~pcf_empty),
    .flush (redirect_valid),
    .rdata (pcf_rdata),
    .count (pcf_count),
    .full  (pcf_full),
    .empty (pcf_empty)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_data_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (keep & (~d_full | id_ready)),
    .wdata (d_wdata),
    .pop   (id_valid & id_ready),
    .flush (redirect_valid),
    .rdata (d_rdata),
    .count (d_count),
    .full  (d_full),
    .empty (d_empty)
  );

  assign id_valid  = ~d_empty;
  assign id_instr  = id_valid ? d_rdata.instr : 32'h0;
  assign id_pc     = id_valid ? d_rdata.pc    : 32'h0;
  assign id_opcode = id_instr[OPCODE_MSB:OPCODE_LSB];
  assign id_rd     = id_instr[RD_MSB:RD_LSB];
  assign id_rs2    = id_instr[RS2_MSB:RS2_LSB];
  assign id_funct7 = id_instr[FUNCT7_MSB:FUNCT7_LSB];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (redirect_valid && mis) state_d = TRAP;
      TRAP:    if (redirect_valid && !mis) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // A redirect drops everything still in flight after this cycle's updates;
  // a held request accepted behind a redirect is stale as well.
  always_comb begin
    if (redirect_valid)
      drop_d = CW'(outstanding + (CW+1)'(accept) - (CW+1)'(imem_rsp_valid));
    else
      drop_d = drop_q - CW'(imem_rsp_valid & (drop_q != '0))
                      + CW'(accept & shadow_vld_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      shadow_pc_q  <= RESET_PC;
      shadow_vld_q <= 1'b0;
      hold_q       <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= imem_req_valid & ~imem_req_ready;
      drop_q  <= drop_d;
      if (redirect_valid) begin
        if (imem_req_valid && !imem_req_ready) begin
          shadow_vld_q <= 1'b1;
          shadow_pc_q  <= target;
        end else begin
          shadow_vld_q <= 1'b0;
          pc_q         <= target;
        end
      end else if (accept) begin
        shadow_vld_q <= 1'b0;
        pc_q         <= shadow_vld_q ? shadow_pc_q : pc_q + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed scoreboard bench for instr_fetch with an in-order imem model.
module tb_instr_fetch;

  logic        clk, rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
  logic [6:0]  id_opcode, id_funct7;
  logic [4:0]  id_rd, id_rs2;
`ifdef FETCH_MISALIGN_EN
  logic        fetch_misaligned;
`endif

  instr_fetch #(.RESET_PC(32'h100), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_opcode      (id_opcode),
    .id_rd          (id_rd),
    .id_rs2         (id_rs2),
    .id_funct7      (id_funct7)
`ifdef FETCH_MISALIGN_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] req_log[$];
  logic [31:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          lat = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h108) return 32'hFE51_2E23;
    return a ^ 32'hC3A5_0013;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < req_log.size()) return req_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction memory: accepts on req handshake, answers in order after lat cycles.
  always @(negedge clk) begin
    cyc++;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
    if (rst_n && imem_req_valid && imem_req_ready) begin
      pend.push_back('{addr: imem_req_addr, due: cyc + lat});
      req_log.push_back(imem_req_addr);
    end
  end

  // Decode-side monitor: every accepted instruction is matched against the scoreboard.
  always @(negedge clk) begin
    logic [31:0] e, w;
    #1;
    if (rst_n && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_id_pc", id_pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        w = mem_word(e);
        chk("id_pc", id_pc, e);
        chk("id_instr", id_instr, w);
        chk("id_opcode", {25'h0, id_opcode}, {25'h0, w[6:0]});
        chk("id_rd", {27'h0, id_rd}, {27'h0, w[11:7]});
        chk("id_rs2", {27'h0, id_rs2}, {27'h0, w[24:20]});
        chk("id_funct7", {25'h0, id_funct7}, {25'h0, w[31:25]});
        if (e == 32'h108) begin
          chk("store_opcode", {25'h0, id_opcode}, 32'h23);
          chk("store_rd", {27'h0, id_rd}, 32'h1C);
          chk("store_rs2", {27'h0, id_rs2}, 32'h5);
          chk("store_funct7", {25'h0, id_funct7}, 32'h7F);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_remaining"}, exp_q.size(), 0);
    exp_q.delete();
    id_ready = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] a);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    chk("after_redirect_id_valid", id_valid, 0);
  endtask

  initial begin
    int idx, t;
    bit found;
    rst_n = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_req_addr", imem_req_addr, 32'h100);
    chk("rst_id_instr", id_instr, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_fields", {id_opcode, id_rd, id_rs2, id_funct7}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #2 chk("idle_no_req", imem_req_valid, 0);

    // Streaming with 1-cycle memory
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h100 + 32'(4 * i));
    @(negedge clk); id_ready = 1'b1;
    drain("stream");
    chk("req0", log_at(0), 32'h100);
    chk("req1", log_at(1), 32'h104);
    chk("req2", log_at(2), 32'h108);

    // Decode backpressure
    repeat (20) @(negedge clk);
    #2;
    chk("bp_req_valid", imem_req_valid, 0);
    chk("bp_id_valid", id_valid, 1);
    chk("bp_req_count", req_log.size(), 10);
    chk("bp_head_pc", id_pc, 32'h120);
    @(negedge clk); #2 chk("bp_instr_stable", id_instr, mem_word(32'h120));
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h120 + 32'(4 * i));
    @(negedge clk); id_ready = 1'b1;
    drain("bp_resume");

    // Redirect with two requests in flight
    repeat (10) @(negedge clk);
    lat = 3;
    exp_q.push_back(32'h130); exp_q.push_back(32'h134);
    id_ready = 1'b1;
    drain("pre_redirect");
    found = 1'b0; t = 0;
    while (!found && t < 50) begin
      @(negedge clk); #2;
      found = (pend.size() == 2) && !id_valid;
      t++;
    end
    chk("two_in_flight", 32'(found), 1);
    redirect(32'h2000);
    exp_q.push_back(32'h2000); exp_q.push_back(32'h2004);
    @(negedge clk); id_ready = 1'b1;
    drain("redirect_inflight");

    // Redirect while a request is stalled
    repeat (10) @(negedge clk);
    lat = 1;
    exp_q.push_back(32'h2008); exp_q.push_back(32'h200C);
    imem_req_ready = 1'b0; id_ready = 1'b1;
    drain("pre_stall");
    idx = req_log.size();
    repeat (3) @(negedge clk);
    #2;
    chk("stall_valid", imem_req_valid, 1);
    chk("stall_addr", imem_req_addr, 32'h2010);
    redirect(32'h400);
    repeat (2) begin
      @(negedge clk); #2;
      chk("stall_hold_valid", imem_req_valid, 1);
      chk("stall_hold_addr", imem_req_addr, 32'h2010);
    end
    exp_q.push_back(32'h400); exp_q.push_back(32'h404);
    @(negedge clk); imem_req_ready = 1'b1; id_ready = 1'b1;
    drain("redirect_stall");
    chk("stall_req_done", log_at(idx), 32'h2010);
    chk("shadow_req", log_at(idx + 1), 32'h400);

    // Redirect coinciding with a response
    repeat (10) @(negedge clk);
    exp_q.push_back(32'h408); exp_q.push_back(32'h40C);
    lat = 3; id_ready = 1'b1;
    drain("pre_same");
    found = 1'b0; t = 0;
    while (!found && t < 50) begin
      @(negedge clk); #2;
      found = (pend.size() > 0) && (pend[0].due == cyc + 1);
      t++;
    end
    chk("rsp_pending", 32'(found), 1);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h600;
    #2 chk("same_cycle_rsp", imem_rsp_valid, 1);
    @(negedge clk);
    redirect_valid = 1'b0;
    #2 chk("same_next_id_valid", id_valid, 0);
    exp_q.push_back(32'h600); exp_q.push_back(32'h604);
    @(negedge clk); id_ready = 1'b1;
    drain("redirect_same");

`ifdef FETCH_MISALIGN_EN
    // Misaligned redirect traps until an aligned one
    repeat (10) @(negedge clk);
    lat = 1;
    redirect(32'h202);
    idx = req_log.size();
    repeat (4) begin
      @(negedge clk); #2;
      chk("trap_flag", fetch_misaligned, 1);
      chk("trap_no_req", imem_req_valid, 0);
      chk("trap_id_valid", id_valid, 0);
    end
    chk("trap_req_count", req_log.size(), idx);
    redirect(32'h300);
    chk("trap_cleared", fetch_misaligned, 0);
    exp_q.push_back(32'h300); exp_q.push_back(32'h304);
    @(negedge clk); id_ready = 1'b1;
    drain("trap_resume");
    chk("trap_resume_req", log_at(idx), 32'h300);
`endif

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
